// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the generic pipeline stage register (pipe_stage_skid)
// and the stages that instantiate it.
//   ps_state_e          : stage occupancy state; the encoding equals the entry count.
//   *_W                 : payload width of each inter-stage register.
//   *_BUBBLE            : value a stage presents when it holds no valid entry.
//                         An all-zero instruction field decodes as NOP.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } ps_state_e;

    localparam int unsigned IFID_W  = 64;
    localparam int unsigned IDEX_W  = 160;
    localparam int unsigned EXMEM_W = 112;
    localparam int unsigned MEMWB_W = 72;

    localparam logic [IFID_W-1:0]  IFID_BUBBLE  = '0;
    localparam logic [IDEX_W-1:0]  IDEX_BUBBLE  = '0;
    localparam logic [EXMEM_W-1:0] EXMEM_BUBBLE = '0;
    localparam logic [MEMWB_W-1:0] MEMWB_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if
// Valid/ready handshake bundle around one pipeline stage register.
//   in_valid/in_ready/in_data    : upstream side (beat offered to the stage)
//   out_valid/out_ready/out_data : downstream side (head entry of the stage)
// Modports:
//   slave  : the stage register itself
//   master : the surrounding pipeline (drives upstream beats, consumes head)
interface pipe_stage_skid_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Generic pipeline stage register with valid/ready handshake and a two-entry
// skid buffer. The payload is opaque. in_ready depends only on the skid
// register and on freeze/flush, so there is no combinational path from
// out_ready to in_ready.
// Ports:
//   clk       : clock, all state updates on the rising edge
//   reset_n   : synchronous active-low reset
//   flush     : discard held entries and any beat offered this cycle
//   freeze    : hold all state; blocks both accept and release
//   bus       : handshake bundle (slave side), see pipe_stage_skid_if
//   occupancy : number of held entries, 0..2
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH  = 64,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               freeze,
    pipe_stage_skid_if.slave   bus,
    output logic [1:0]         occupancy
);

    ps_state_e        state, state_nxt;
    logic             head_v, skid_v;
    logic [WIDTH-1:0] head_data, head_nxt;
    logic [WIDTH-1:0] skid_data, skid_nxt;
    logic             acc, rel;

    assign bus.in_ready  = !skid_v && !freeze && !flush;
    assign acc           = bus.in_valid && bus.in_ready;
    assign rel           = head_v && bus.out_ready && !freeze;

    assign bus.out_valid = head_v;
    assign bus.out_data  = head_data;
    assign occupancy     = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= PS_EMPTY;
            head_v    <= 1'b0;
            skid_v    <= 1'b0;
            head_data <= BUBBLE;
            skid_data <= BUBBLE;
        end else begin
            state     <= state_nxt;
            head_v    <= (state_nxt != PS_EMPTY);
            skid_v    <= (state_nxt == PS_FULL);
            head_data <= head_nxt;
            skid_data <= skid_nxt;
        end
    end

    // Vacated registers are refilled with BUBBLE so out_data comes straight
    // from head_data and still reads BUBBLE whenever out_valid is low.
    always_comb begin
        state_nxt = state;
        head_nxt  = head_data;
        skid_nxt  = skid_data;
        if (flush) begin
            state_nxt = PS_EMPTY;
            head_nxt  = BUBBLE;
            skid_nxt  = BUBBLE;
        end else begin
            unique case (state)
                PS_EMPTY: begin
                    if (acc) begin
                        state_nxt = PS_ONE;
                        head_nxt  = bus.in_data;
                    end
                end
                PS_ONE: begin
                    if (acc && rel) begin
                        head_nxt  = bus.in_data;
                    end else if (acc) begin
                        state_nxt = PS_FULL;
                        skid_nxt  = bus.in_data;
                    end else if (rel) begin
                        state_nxt = PS_EMPTY;
                        head_nxt  = BUBBLE;
                    end
                end
                PS_FULL: begin
                    if (rel) begin
                        state_nxt = PS_ONE;
                        head_nxt  = skid_data;
                        skid_nxt  = BUBBLE;
                    end
                end
                default: begin
                    state_nxt = PS_EMPTY;
                    head_nxt  = BUBBLE;
                    skid_nxt  = BUBBLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It replaces the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block that carries an opaque payload. It adds back-pressure without a combinational ready path, plus freeze and flush controls with a configurable bubble value. It sits between any two pipeline stages; the hazard unit drives `freeze`/`flush`.

## Interface
- `WIDTH`, 64: payload width in bits (≥1).
- `BUBBLE`, 0: `WIDTH`-bit value presented on `out_data` whenever no valid entry is at the head (NOP encoding for instruction-carrying stages).
- `clk  in  1`: single clock, all state updates on rising edge.
- `reset_n  in  1`: reset, synchronous and active-low.
- `flush  in  1`: discard all held entries and any beat offered this cycle.
- `freeze  in  1`: hold state; blocks both input accept and output release.
- `in_valid  in  1`: upstream beat offered.
- `in_ready  out  1`: stage can accept a beat this cycle.
- `in_data  in  WIDTH`: upstream payload.
- `out_valid  out  1`: head entry valid.
- `out_ready  in  1`: downstream consumes head this cycle.
- `out_data  out  WIDTH`: head payload, or `BUBBLE` when `out_valid`=0.
- `occupancy  out  2`: number of held entries, 0..2.

## Operation
- Storage: head register (`head_data`, `head_v`) drives the outputs. Skid register (`skid_data`, `skid_v`) catches a beat accepted while the head is stalled.
- States: EMPTY (0 entries), ONE (head only), FULL (head+skid). `skid_v`=1 never occurs with `head_v`=0.
- `acc` = `in_valid & in_ready`; `rel` = `out_valid & out_ready & !freeze`.
- `in_ready` = `!skid_v & !freeze & !flush`. Its only dependence on registered state is `skid_v`; there is no path from `out_ready`.
- Transitions, when neither flush nor reset is asserted:
  - EMPTY: acc → ONE, head←in.
  - ONE: acc&rel → ONE, head←in. acc&!rel → FULL, skid←in. !acc&rel → EMPTY. Else hold.
  - FULL: rel → ONE, head←skid (acc impossible, `in_ready`=0). Else hold.
- freeze=1: no acc, no rel; all registers hold, including payload.
- flush=1, regardless of freeze or in_valid: next state EMPTY, `head_data` and `skid_data` ← `BUBBLE`, offered beat dropped.
- Priority: reset > flush > freeze > handshake.
- `occupancy` = `head_v + skid_v`, registered-derived.
- Payload bits are never modified; the block is width-agnostic.

## Timing
- Reset (`reset_n`=0 at an edge): state EMPTY, `out_valid`=0, `out_data`=`BUBBLE`, `occupancy`=0. `in_ready`=1 the cycle after reset deasserts, unless freeze or flush is asserted. Reset mid-transfer drops all entries.
- Latency: a beat accepted at edge N into EMPTY or ONE-with-release appears on `out_data` after edge N (one cycle).
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- Stall: `out_ready` low for k≥1 cycles absorbs exactly one extra beat. `in_ready` falls the cycle after the skid fills.
- Order is strictly FIFO; no beat is duplicated or lost except by flush or reset.
- A flush edge with a simultaneous release: the downstream sampled the head on that edge. The flush still empties the stage afterwards.
- Outputs `out_valid`, `out_data` and `occupancy` are pure register outputs.

## Structure
- Shared package `pipe_pkg`:
  - State encoding constants `PS_EMPTY`/`PS_ONE`/`PS_FULL`.
  - Per-stage payload width constants (`IDEX_W` etc.).
  - Per-stage bubble constants (`IDEX_BUBBLE`, instruction field = 0 / NOP).
- No sub-module: a single flat module. The skid and head registers are two instances of identical always-block logic, not worth splitting out.

## Test plan
- Reset then stream: `out_ready`=1, beats 0x11,0x22,0x33 on consecutive cycles → `out_data` 0x11,0x22,0x33 one cycle later each, `occupancy`=1 throughout, `in_ready` stays 1.
- Back-pressure: stream 0xA1..0xA4, `out_ready`=0 for 3 cycles after 0xA1 is at head → 0xA2 in skid, `in_ready`=0, `occupancy`=2. On release, output order is 0xA1,0xA2,0xA3,0xA4 with no gaps or duplicates.
- Freeze: FULL with head 0x5, skid 0x6, `freeze`=1 for 4 cycles with `in_valid`=1, `out_ready`=1 → all outputs constant, `in_ready`=0. After freeze drops: 0x5 then 0x6 released.
- Flush dominance: FULL, `flush`=`freeze`=`in_valid`=1 at the same edge → next cycle `out_valid`=0, `out_data`=`BUBBLE`, `occupancy`=0. The offered beat never appears.
- Reset mid-operation: `occupancy`=2, `reset_n`=0 for one edge → EMPTY, `out_data`=`BUBBLE`. The following beat 0x77 has 1-cycle latency.
- Random valid/ready (10k cycles, WIDTH=1 and WIDTH=200) against a scoreboard FIFO → order preserved, `occupancy` matches the model, `in_ready` never depends combinationally on `out_ready`.
